// File: rtl/mdio_pkg.sv
// mdio_pkg: shared FSM states, Clause-22 frame codes and per-state bit counts for mdio_master.
package mdio_pkg;
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE} state_e;
    localparam logic [1:0] ST        = 2'b01;
    localparam logic [1:0] OP_WR     = 2'b01;
    localparam logic [1:0] OP_RD     = 2'b10;
    localparam logic [5:0] PRE_BITS  = 6'd32;
    localparam logic [5:0] HDR_BITS  = 6'd14;
    localparam logic [5:0] TA_BITS   = 6'd2;
    localparam logic [5:0] DATA_BITS = 6'd16;
    function automatic state_e next_state(input state_e s);
        return s == S_PRE ? S_HDR : s == S_HDR ? S_TA : s == S_TA ? S_DATA : S_DONE;
    endfunction
    function automatic logic [5:0] state_bits(input state_e s);
        return s == S_PRE ? PRE_BITS : s == S_HDR ? HDR_BITS : s == S_TA ? TA_BITS :
               s == S_DATA ? DATA_BITS : 6'd0;
    endfunction
endpackage

// File: rtl/mdio_clk_gen.sv
// mdio_clk_gen: Mdc divider (low then high, CLK_DIV cycles each) with strobes in the
// cycle before each bit start (fall_tick_o) and each Mdc rise (rise_tick_o).
module mdio_clk_gen #(
    parameter int CLK_DIV = 20
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic hold_i,
    output logic mdc_o,
    output logic fall_tick_o,
    output logic rise_tick_o
);
    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);
    logic [7:0] cnt_q;
    logic ph_q, mdc_q, last;
    assign last        = cnt_q == LAST;
    assign fall_tick_o = !hold_i && last && ph_q;
    assign rise_tick_o = !hold_i && last && !ph_q;
    assign mdc_o       = mdc_q;
    // Parked at the end of a high phase so the first released cycle starts a bit period.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= LAST;
            ph_q  <= 1'b1;
            mdc_q <= 1'b0;
        end else if (hold_i) begin
            cnt_q <= LAST;
            ph_q  <= 1'b1;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= last ? 8'd0 : cnt_q + 8'd1;
            ph_q  <= last ? !ph_q : ph_q;
            mdc_q <= rise_tick_o ? 1'b1 : fall_tick_o ? 1'b0 : mdc_q;
        end
    end
endmodule

// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO management master. Define MDIO_PREAMBLE_SUPPRESS_EN to add
// cfg_no_preamble, which skips the 32-bit preamble for a command when set at acceptance.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV = 20
) (
    input  logic        clk_sys,
    input  logic        rstn,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    input  logic        cfg_no_preamble,
`endif
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_is_rd,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wr_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_rd_data,
    output logic        rsp_err,
    output logic        busy,
    input  logic        Mdi,
    output logic        Mdo,
    output logic        MdoEn,
    output logic        Mdc
);
    state_e      state_q, emit_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] sh_q;
    logic [15:0] rd_sh_q, rd_data_q;
    logic        is_rd_q, ta_err_q, err_q, ready_q, valid_q, mdo_q, mdo_en_q;
    logic        drive_d, start_pre, fall_tick, rise_tick;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    assign start_pre = !cfg_no_preamble;
`else
    assign start_pre = 1'b1;
`endif

    mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk (
        .clk_i       (clk_sys),
        .rst_ni      (rstn),
        .hold_i      (state_q == S_IDLE),
        .mdc_o       (Mdc),
        .fall_tick_o (fall_tick),
        .rise_tick_o (rise_tick)
    );

    // emit_d is the state owning the bit launched at the next fall_tick.
    always_comb begin
        emit_d  = cnt_q != 6'd0 ? state_q : next_state(state_q);
        cnt_d   = (cnt_q != 6'd0 ? cnt_q : state_bits(emit_d)) - 6'd1;
        drive_d = emit_d == S_PRE || emit_d == S_HDR || (!is_rd_q && emit_d != S_DONE);
    end

    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            sh_q      <= 32'd0;
            rd_sh_q   <= 16'd0;
            rd_data_q <= 16'd0;
            is_rd_q   <= 1'b0;
            ta_err_q  <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            mdo_q     <= 1'b0;
            mdo_en_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (state_q == S_IDLE) begin
                ready_q <= !(cmd_valid && ready_q);
                if (cmd_valid && ready_q) begin
                    state_q <= start_pre ? S_PRE : S_HDR;
                    cnt_q   <= start_pre ? PRE_BITS : HDR_BITS;
                    is_rd_q <= cmd_is_rd;
                    sh_q    <= {ST, cmd_is_rd ? OP_RD : OP_WR, cmd_phy_addr, cmd_reg_addr,
                                2'b10, cmd_wr_data};
                end
            end else if (state_q == S_DONE) begin
                state_q <= S_IDLE;
                ready_q <= 1'b1;
            end else begin
                if (rise_tick && state_q == S_TA && cnt_q == 6'd0)
                    ta_err_q <= Mdi;
                if (rise_tick && state_q == S_DATA)
                    rd_sh_q <= {rd_sh_q[14:0], Mdi};
                if (fall_tick) begin
                    state_q  <= emit_d;
                    cnt_q    <= emit_d == S_DONE ? 6'd0 : cnt_d;
                    mdo_q    <= drive_d && (emit_d == S_PRE || sh_q[31]);
                    mdo_en_q <= drive_d;
                    if (emit_d != S_PRE)
                        sh_q <= {sh_q[30:0], 1'b0};
                    if (emit_d == S_DONE) begin
                        valid_q <= 1'b1;
                        if (is_rd_q) begin
                            rd_data_q <= rd_sh_q;
                            err_q     <= ta_err_q;
                        end
                    end
                end
            end
        end
    end

    assign cmd_ready   = ready_q;
    assign busy        = state_q != S_IDLE;
    assign rsp_valid   = valid_q;
    assign rsp_rd_data = rd_data_q;
    assign rsp_err     = err_q && is_rd_q;
    assign Mdo         = mdo_q;
    assign MdoEn       = mdo_en_q;
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: scoreboard bench for mdio_master at CLK_DIV=4 with an MDIO responder model.
// Define MDIO_PREAMBLE_SUPPRESS_EN to also exercise cfg_no_preamble.
`timescale 1ns/1ps
module tb_mdio_master;
    localparam int DIV = 4;
    logic        clk_sys = 1'b0, rstn = 1'b0, cmd_valid = 1'b0, cmd_is_rd = 1'b0, Mdi = 1'b1;
    logic [4:0]  cmd_phy_addr = '0, cmd_reg_addr = '0;
    logic [15:0] cmd_wr_data = '0;
    logic        cmd_ready, rsp_valid, rsp_err, busy, Mdo, MdoEn, Mdc;
    logic [15:0] rsp_rd_data;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    logic        cfg_no_preamble = 1'b0;
`endif

    mdio_master #(.CLK_DIV(DIV)) dut (
        .clk_sys         (clk_sys),
        .rstn            (rstn),
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        .cfg_no_preamble (cfg_no_preamble),
`endif
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_is_rd       (cmd_is_rd),
        .cmd_phy_addr    (cmd_phy_addr),
        .cmd_reg_addr    (cmd_reg_addr),
        .cmd_wr_data     (cmd_wr_data),
        .rsp_valid       (rsp_valid),
        .rsp_rd_data     (rsp_rd_data),
        .rsp_err         (rsp_err),
        .busy            (busy),
        .Mdi             (Mdi),
        .Mdo             (Mdo),
        .MdoEn           (MdoEn),
        .Mdc             (Mdc)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          hs;
        int          nbits;
        logic [63:0] mdo;
        logic [63:0] en;
    } exp_t;

    exp_t        sb[$];
    exp_t        got_e;
    int          checks = 0, failures = 0, cyc = 0, nb = 0, last_rsp = -100;
    int          overlap = 0, hi_glitch = 0;
    logic [63:0] cap_mdo = '0, cap_en = '0;
    logic        prev_mdc = 1'b0, prev_mdo = 1'b0, resp_hold1 = 1'b0;
    logic [15:0] resp_data = '0, model_rd = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Observer, responder and scoreboard consumer, all sampled on the falling edge.
    always @(negedge clk_sys) begin
        if (cmd_valid && cmd_ready) begin
            nb = 0;
            cap_mdo = '0;
            cap_en = '0;
        end
        if (Mdc && !prev_mdc) begin
            cap_mdo = {cap_mdo[62:0], Mdo};
            cap_en = {cap_en[62:0], MdoEn};
            nb++;
        end
        if (Mdc && prev_mdc && Mdo !== prev_mdo) hi_glitch++;
        if (cmd_ready && rsp_valid) overlap++;
        Mdi = resp_hold1 ? 1'b1 : nb == 47 ? 1'b0 :
              (nb >= 48 && nb < 64) ? resp_data[4'(63 - nb)] : 1'b1;
        if (rsp_valid) begin
            if (sb.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
            else begin
                got_e = sb.pop_front();
                chk("latency", 64'(cyc - got_e.hs - 1), 64'(got_e.nbits * 2 * DIV + 1));
                chk("nbits", 64'(nb), 64'(got_e.nbits));
                chk("mdo_stream", cap_mdo, got_e.mdo);
                chk("mdoen_stream", cap_en, got_e.en);
                chk("rd_data", 64'(rsp_rd_data), 64'(got_e.data));
                chk("rsp_err", 64'(rsp_err), 64'(got_e.err));
                chk("done_pads", 64'({Mdc, Mdo, MdoEn, busy}), 64'b0001);
            end
            last_rsp = cyc;
        end
        prev_mdc = Mdc;
        prev_mdo = Mdo;
    end

    task automatic send(input logic rd, input logic [4:0] phy, input logic [4:0] regad,
                        input logic [15:0] wd, input logic [15:0] rdat, input logic h1,
                        input logic np, input bit keep, input bit gap);
        exp_t e;
        int t;
        logic [31:0] body, en32;
        @(posedge clk_sys);
        #1;
        cmd_valid = 1'b1;
        cmd_is_rd = rd;
        cmd_phy_addr = phy;
        cmd_reg_addr = regad;
        cmd_wr_data = wd;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        cfg_no_preamble = np;
`endif
        t = 0;
        @(negedge clk_sys);
        while (!cmd_ready && t < 2000) begin
            @(negedge clk_sys);
            t++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        if (gap) chk("b2b_gap", 64'(cyc - last_rsp), 64'd1);
        resp_data = rdat;
        resp_hold1 = h1;
        body = {2'b01, rd ? 2'b10 : 2'b01, phy, regad, rd ? 18'h0 : {2'b10, wd}};
        en32 = rd ? 32'hFFFC_0000 : 32'hFFFF_FFFF;
        e.nbits = np ? 32 : 64;
        e.mdo = np ? {32'h0, body} : {32'hFFFF_FFFF, body};
        e.en = np ? {32'h0, en32} : {32'hFFFF_FFFF, en32};
        e.hs = cyc;
        e.data = rd ? (h1 ? 16'hFFFF : rdat) : model_rd;
        e.err = rd && h1;
        if (rd) model_rd = e.data;
        sb.push_back(e);
        @(posedge clk_sys);
        #1;
        cmd_valid = keep;
        cmd_is_rd = 1'($urandom);
        cmd_phy_addr = 5'($urandom);
        cmd_reg_addr = 5'($urandom);
        cmd_wr_data = 16'($urandom);
    endtask

    task automatic wait_done();
        int t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(negedge clk_sys);
            t++;
        end
        chk("rsp_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_ctrl", 64'({cmd_ready, busy, rsp_valid, rsp_err}), 64'd0);
        chk("rst_pads", 64'({Mdc, Mdo, MdoEn}), 64'd0);
        chk("rst_rd_data", 64'(rsp_rd_data), 64'd0);
        @(negedge clk_sys) rstn = 1'b1;
        @(posedge clk_sys);
        #1;
        chk("ready_after_rst", 64'(cmd_ready), 64'd1);

        send(1'b0, 5'h01, 5'h00, 16'h1200, 16'h0, 1'b0, 1'b0, 0, 0);
        wait_done();
        send(1'b1, 5'h1F, 5'h02, 16'h0, 16'h0022, 1'b0, 1'b0, 0, 0);
        wait_done();
        send(1'b1, 5'h0A, 5'h11, 16'h0, 16'h1234, 1'b1, 1'b0, 0, 0);
        wait_done();
        send(1'b0, 5'h15, 5'h0C, 16'h5A3C, 16'h0, 1'b0, 1'b0, 0, 0);
        wait_done();

        send(1'b0, 5'h05, 5'h0A, 16'hBEEF, 16'h0, 1'b0, 1'b0, 0, 0);
        t = 0;
        while (nb < 41 && t < 2000) begin
            @(negedge clk_sys);
            t++;
        end
        chk("reach_bit40", 64'(nb), 64'd41);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_pads", 64'({Mdc, Mdo, MdoEn}), 64'd0);
        chk("async_rst_ctrl", 64'({busy, cmd_ready, rsp_valid}), 64'd0);
        chk("async_rst_rd_data", 64'(rsp_rd_data), 64'd0);
        sb.delete();
        model_rd = '0;
        repeat (3) @(negedge clk_sys);
        rstn = 1'b1;
        repeat (100) @(negedge clk_sys);
        chk("no_rsp_after_abort", 64'(busy), 64'd0);
        send(1'b0, 5'h12, 5'h1F, 16'hA5C3, 16'h0, 1'b0, 1'b0, 0, 0);
        wait_done();

        send(1'b0, 5'h03, 5'h04, 16'h0F0F, 16'h0, 1'b0, 1'b0, 1, 0);
        send(1'b1, 5'h07, 5'h08, 16'h0, 16'h8001, 1'b0, 1'b0, 0, 1);
        wait_done();
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        send(1'b0, 5'h09, 5'h03, 16'hC0DE, 16'h0, 1'b0, 1'b1, 0, 0);
        wait_done();
`endif
        repeat (10) @(negedge clk_sys);
        chk("ready_rsp_overlap", 64'(overlap), 64'd0);
        chk("mdo_stable_high", 64'(hi_glitch), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 20, giving clk_sys cycles per Mdc half-period; legal range 2..255.
REQ-002 SHALL have port clk_sys  input  1  system clock, the only clock; one clock, all logic on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  high only in IDLE.
REQ-006 SHALL have port cmd_is_rd  input  1  1 = read, 0 = write.
REQ-007 SHALL have port cmd_phy_addr  input  5  PHYAD.
REQ-008 SHALL have port cmd_reg_addr  input  5  REGAD.
REQ-009 SHALL have port cmd_wr_data  input  16  write data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rd_data  output  16  read data, held until the next completion.
REQ-012 SHALL have port rsp_err  output  1  read TA error, valid with rsp_valid.
REQ-013 SHALL have port busy  output  1  transaction in progress.
REQ-014 SHALL have ports Mdi input 1, Mdo output 1, MdoEn output 1 and Mdc output 1 for the MDIO pad signals.

Function
REQ-015 SHALL accept a command on a clk_sys edge with cmd_valid && cmd_ready, latching all cmd_* fields; cmd_* are ignored at all other times.
REQ-016 SHALL send the Clause-22 frame MSB-first: 32 preamble ones, ST=01, OP (01 write, 10 read), PHYAD, REGAD, TA, 16 data bits — 64 bit periods in total.
REQ-017 SHALL make each bit period 2*CLK_DIV cycles: Mdc low for CLK_DIV cycles, then high for CLK_DIV cycles; Mdc is low when idle.
REQ-018 SHALL update Mdo only in the first cycle of a bit period, while Mdc is low.
REQ-019 SHALL drive TA=10 with MdoEn=1 on a write, and drive the data bits with MdoEn=1.
REQ-020 SHALL hold MdoEn=0 on a read from the first TA bit through the last data bit.
REQ-021 SHALL sample Mdi on a read in the cycle Mdc rises, in the second TA bit and in each data bit.
REQ-022 SHALL set rsp_err=1 if the second-TA sample is 1; data is still shifted in.
REQ-023 SHALL use FSM states IDLE -> PRE -> HDR (ST, OP, PHYAD, REGAD: 14 bits) -> TA (2 bits) -> DATA (16 bits) -> DONE -> IDLE, with a 6-bit bit counter reloaded per state.
REQ-024 SHALL spend exactly one cycle in DONE: rsp_valid=1, busy=1, Mdc=0, MdoEn=0, Mdo=0.
REQ-025 SHALL place rsp_valid exactly 128*CLK_DIV+1 cycles after the acceptance edge, with cmd_ready returning high on the following cycle.
REQ-026 SHALL keep busy = !IDLE.
REQ-027 SHALL never assert cmd_ready and rsp_valid in the same cycle; a command held through DONE is accepted on the first IDLE cycle.
REQ-028 SHALL leave rsp_rd_data unchanged by write transactions.
REQ-029 SHALL not modify rsp_err for a write; it reads 0 with rsp_valid.

Reset
REQ-030 SHALL on rstn low, immediately and asynchronously, enter IDLE with Mdc=0, Mdo=0, MdoEn=0, busy=0, cmd_ready=0 (1 from the first clock after release), rsp_valid=0, rsp_rd_data=0, rsp_err=0 and counters cleared.
REQ-031 SHALL abort any transaction in progress on reset with no rsp_valid pulse; the next command after release starts with a full frame.

Configuration
REQ-032 SHALL, with MDIO_PREAMBLE_SUPPRESS_EN defined, add input port cfg_no_preamble (1 bit), sampled at acceptance; when 1 the PRE state is skipped, the frame is 32 bit periods and rsp_valid arrives 64*CLK_DIV+1 cycles after acceptance.
REQ-033 SHALL, without MDIO_PREAMBLE_SUPPRESS_EN, have no cfg_no_preamble port and always send the 32-bit preamble.

Structure
REQ-034 SHALL place in a shared package mdio_pkg: the FSM state enum, the OP codes (OP_WR=2'b01, OP_RD=2'b10), ST=2'b01 and bit-count constants (PRE_BITS=32, HDR_BITS=14, TA_BITS=2, DATA_BITS=16).
REQ-035 SHALL instantiate one sub-module, mdio_clk_gen, that generates Mdc plus single-cycle fall_tick/rise_tick strobes from CLK_DIV and is held in phase reset while IDLE.

Verification (CLK_DIV=4)
REQ-036 SHALL cover a write of PHY 0x01, REG 0x00, data 0x1200: the Mdo bitstream equals 32x1, 0101 00001 00000 10, 0x1200; MdoEn=1 throughout; rsp_valid 513 cycles after acceptance.
REQ-037 SHALL cover a read of PHY 0x1F, REG 0x02 with the responder driving TA0=0 and data 0x0022: rsp_rd_data=0x0022, rsp_err=0, MdoEn=0 for the last 18 bit periods.
REQ-038 SHALL cover a read with Mdi held at 1: rsp_err=1 and rsp_rd_data=0xFFFF.
REQ-039 SHALL cover rstn pulsed low at bit 40 of a write: Mdc, Mdo and MdoEn drop to 0 asynchronously, there is no rsp_valid, and the next write produces a complete correct frame.
REQ-040 SHALL cover back-to-back commands with cmd_valid held high: the second is accepted one cycle after the first rsp_valid, and there is never overlap of cmd_ready and rsp_valid.
REQ-041 SHALL cover, with MDIO_PREAMBLE_SUPPRESS_EN and cfg_no_preamble=1, a write that shows no preamble bits and rsp_valid at 257 cycles.
